fprti_issue: RTL and testbench
==============================

FPRTI_ISSUE -- requirements
Module: fprti_issue

Interface
REQ-001 SHALL have parameter NUM_FPRTI_REGS, default 16: number of 32-bit operand registers.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum number of WAIT cycles before abort; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en_i, input, 1 bit: CPU operand-write strobe.
REQ-006 SHALL have port wr_addr_i, input, $clog2(NUM_FPRTI_REGS) bits: operand register index.
REQ-007 SHALL have port wr_data_i, input, 32 bits: FP32 operand write data.
REQ-008 SHALL have port start_i, input, 1 bit: launch request.
REQ-009 SHALL have port fprti_regs_o, output, unpacked array [NUM_FPRTI_REGS] of 32 bits: operands to the intersection unit.
REQ-010 SHALL have port input_valid_o, output, 1 bit: issue strobe to the intersection unit.
REQ-011 SHALL have port return_i, input, 32 bits: result from the intersection unit.
REQ-012 SHALL have port output_valid_i, input, 1 bit: result-valid strobe from the intersection unit.
REQ-013 SHALL have port busy_o, output, 1 bit: an operation is in flight.
REQ-014 SHALL have port done_o, output, 1 bit: 1-cycle completion pulse.
REQ-015 SHALL have port result_o, output, 32 bits: last captured result.
REQ-016 SHALL have port timeout_o, output, 1 bit: sticky flag, set when the last operation aborted.
REQ-017 SHALL have port wr_reject_o, output, 1 bit: 1-cycle pulse when a write is dropped.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE. Each state lasts one cycle except IDLE and WAIT.
REQ-019 IDLE: start_i=1 SHALL move the FSM to ISSUE. Otherwise the FSM SHALL stay in IDLE.
REQ-020 ISSUE: input_valid_o SHALL be 1 for exactly this cycle, and the FSM SHALL go to WAIT. output_valid_i SHALL be ignored in ISSUE.
REQ-021 WAIT: output_valid_i=1 SHALL register return_i into result_o, and the FSM SHALL go to DONE.
REQ-022 WAIT: a 16-bit counter SHALL clear on entry and increment each WAIT cycle. When the count reaches TIMEOUT_CYCLES-1 and output_valid_i=0, the block SHALL load result_o=32'h7FC0_0000 (qNaN), set timeout_o, and go to DONE.
REQ-023 WAIT: if output_valid_i=1 in the terminal-count cycle, the result SHALL win and timeout_o SHALL stay 0.
REQ-024 DONE: done_o SHALL be 1 for this cycle, and the FSM SHALL return to IDLE.
REQ-025 busy_o SHALL equal 1 in ISSUE and WAIT only.
REQ-026 Latency: start_i at cycle N SHALL give input_valid_o at N+1. output_valid_i at cycle M≥N+2 SHALL give result_o valid and done_o=1 at M+1. Minimum start-to-done is 3 cycles.
REQ-027 Operand write in IDLE or DONE: the write SHALL update fprti_regs_o[wr_addr_i] on the next edge.
REQ-028 Write and start_i in the same IDLE cycle: the new value SHALL be visible on fprti_regs_o during ISSUE.
REQ-029 wr_en_i while busy_o=1: the write SHALL be dropped, wr_reject_o SHALL pulse the next cycle, and operands SHALL stay unchanged.
REQ-030 start_i while not in IDLE SHALL be ignored, with no queuing.
REQ-031 output_valid_i in IDLE or DONE SHALL be ignored; result_o SHALL be unchanged.
REQ-032 timeout_o SHALL clear on the cycle the FSM enters ISSUE.
REQ-033 wr_addr_i ≥ NUM_FPRTI_REGS (non-power-of-2 configurations only) SHALL be ignored without a reject pulse.
REQ-034 fprti_regs_o SHALL be driven directly from registers, with no combinational path from wr_data_i.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: FSM=IDLE, all operand registers=0, result_o=0, counter=0.
REQ-036 rst_n=0 SHALL asynchronously force all 1-bit outputs (input_valid_o, busy_o, done_o, timeout_o, wr_reject_o) to 0.
REQ-037 Reset asserted mid-operation SHALL abort the operation without a done_o pulse. A later output_valid_i SHALL be ignored.
REQ-038 Deassertion SHALL be synchronized so that the first active edge after rst_n rises is a normal cycle.

Verification
REQ-039 Basic: write regs 0..14 with 32'h3F80_0000+i, pulse start_i; the responder answers return_i=32'h4020_0000 three cycles after input_valid_o -> fprti_regs_o matches the writes, done_o=1 one cycle after output_valid_i, result_o=32'h4020_0000, busy_o=0 after done.
REQ-040 Timeout: TIMEOUT_CYCLES=8, responder silent -> done_o 9 cycles after input_valid_o, result_o=32'h7FC0_0000, timeout_o=1; the next start clears timeout_o.
REQ-041 Edge race: output_valid_i in the terminal-count cycle -> result captured, timeout_o=0.
REQ-042 Busy protection: write reg 3 and pulse start_i during WAIT -> wr_reject_o pulses, reg 3 unchanged, no second input_valid_o.
REQ-043 Same-cycle write+start: write reg 5=32'hDEAD_BEEF with start_i -> fprti_regs_o[5]=32'hDEAD_BEEF at input_valid_o.
REQ-044 Reset mid-WAIT: assert rst_n=0, then send output_valid_i after release -> all outputs 0, no done_o, result_o=0.

Source files
------------

// File: rtl/fprti_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : fprti_issue_if
// Brief    : Bus bundle between the CPU/intersection side and fprti_issue.
//            master = environment (CPU + intersection unit), slave = issuer.
// Revision : 1.0 - initial release
// ============================================================================
interface fprti_issue_if #(
   parameter int NUM_FPRTI_REGS = 16
);
   localparam int c_ADDR_W = (NUM_FPRTI_REGS > 1) ? $clog2(NUM_FPRTI_REGS) : 1;

   // CPU operand writes and launch
   logic                wr_en_i;
   logic [c_ADDR_W-1:0] wr_addr_i;
   logic [31:0]         wr_data_i;
   logic                start_i;
   // Intersection unit handshake
   logic [31:0]         fprti_regs_o [NUM_FPRTI_REGS];
   logic                input_valid_o;
   logic [31:0]         return_i;
   logic                output_valid_i;
   // Status
   logic                busy_o;
   logic                done_o;
   logic [31:0]         result_o;
   logic                timeout_o;
   logic                wr_reject_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, start_i, return_i, output_valid_i,
      input  fprti_regs_o, input_valid_o, busy_o, done_o, result_o, timeout_o,
             wr_reject_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, start_i, return_i, output_valid_i,
      output fprti_regs_o, input_valid_o, busy_o, done_o, result_o, timeout_o,
             wr_reject_o
   );
endinterface
`default_nettype wire

// File: rtl/fprti_issue.sv
`default_nettype none
// ============================================================================
// Module   : fprti_issue
// Brief    : Holds FP32 operands for the ray/triangle intersection unit,
//            issues one request on start, waits for the result with a
//            bounded timeout (qNaN on abort) and reports completion.
// Revision : 1.0 - initial release
// ============================================================================
module fprti_issue #(
   parameter int NUM_FPRTI_REGS = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire              clk,
   input  wire              rst_n,
   fprti_issue_if.slave     bus
);
   localparam int          c_ADDR_W = (NUM_FPRTI_REGS > 1) ? $clog2(NUM_FPRTI_REGS) : 1;
   localparam logic [15:0] c_TERM   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] c_QNAN   = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_result;
   logic        r_input_valid;
   logic        r_busy;
   logic        r_done;
   logic        r_timeout;
   logic        r_wr_reject;
   logic [31:0] r_regs [NUM_FPRTI_REGS];
   logic        w_addr_ok;

   // Indices past the last register only exist when the count is not a power of two
   if ((2 ** c_ADDR_W) == NUM_FPRTI_REGS) begin : g_addr_full
      assign w_addr_ok = 1'b1;
   end else begin : g_addr_chk
      assign w_addr_ok = (32'(bus.wr_addr_i) < NUM_FPRTI_REGS);
   end

   // Sequencer: all handshake/status outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= 16'd0;
         r_result      <= 32'd0;
         r_input_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_input_valid <= 1'b0;
         r_done        <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_state       <= S_ISSUE;
                  r_input_valid <= 1'b1;
                  r_busy        <= 1'b1;
                  r_timeout     <= 1'b0;
               end
            end
            S_ISSUE: begin
               // Result strobes are not yet meaningful here; counter starts fresh
               r_state <= S_WAIT;
               r_cnt   <= 16'd0;
            end
            S_WAIT: begin
               // A result arriving on the terminal count beats the timeout
               if (bus.output_valid_i) begin
                  r_result <= bus.return_i;
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else if (r_cnt == c_TERM) begin
                  r_result  <= c_QNAN;
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Operand file: writes land when idle/done, are dropped with a pulse when busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_reject <= 1'b0;
         for (int i = 0; i < NUM_FPRTI_REGS; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else begin
         r_wr_reject <= 1'b0;
         if (bus.wr_en_i && w_addr_ok) begin
            if (r_busy) begin
               r_wr_reject <= 1'b1;
            end else begin
               r_regs[bus.wr_addr_i] <= bus.wr_data_i;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_FPRTI_REGS; g++) begin : g_regs_out
      assign bus.fprti_regs_o[g] = r_regs[g];
   end

   assign bus.input_valid_o = r_input_valid;
   assign bus.busy_o        = r_busy;
   assign bus.done_o        = r_done;
   assign bus.result_o      = r_result;
   assign bus.timeout_o     = r_timeout;
   assign bus.wr_reject_o   = r_wr_reject;

endmodule
`default_nettype wire

// File: tb/tb_fprti_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fprti_issue
// Brief    : Directed self-checking bench for fprti_issue (TIMEOUT_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fprti_issue;
   localparam int c_NUM = 16;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fprti_issue_if #(.NUM_FPRTI_REGS(c_NUM)) bus ();

   fprti_issue #(
      .NUM_FPRTI_REGS (c_NUM),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.wr_en_i        = 1'b0;
      bus.wr_addr_i      = '0;
      bus.wr_data_i      = 32'd0;
      bus.start_i        = 1'b0;
      bus.return_i       = 32'd0;
      bus.output_valid_i = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busy",   32'(bus.busy_o), 32'd0);
      chk("rst_ivalid", 32'(bus.input_valid_o), 32'd0);
      chk("rst_done",   32'(bus.done_o), 32'd0);
      chk("rst_tmo",    32'(bus.timeout_o), 32'd0);
      chk("rst_result", bus.result_o, 32'd0);
      chk("rst_reg0",   bus.fprti_regs_o[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic: load regs 0..14
      for (int i = 0; i < 15; i++) begin
         bus.wr_en_i   = 1'b1;
         bus.wr_addr_i = 4'(i);
         bus.wr_data_i = 32'h3F80_0000 + 32'(i);
         tick();
      end
      bus.wr_en_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("basic_reg%0d", i), bus.fprti_regs_o[i], 32'h3F80_0000 + 32'(i));
      end
      chk("basic_reg15", bus.fprti_regs_o[15], 32'd0);
      bus.start_i = 1'b1;
      tick();                                   // ISSUE (I)
      bus.start_i = 1'b0;
      chk("basic_ivalid", 32'(bus.input_valid_o), 32'd1);
      chk("basic_busy",   32'(bus.busy_o), 32'd1);
      tick();                                   // I+1
      chk("basic_ivalid_once", 32'(bus.input_valid_o), 32'd0);
      tick();                                   // I+2
      tick();                                   // I+3: responder answers
      bus.output_valid_i = 1'b1;
      bus.return_i       = 32'h4020_0000;
      chk("basic_nodone_early", 32'(bus.done_o), 32'd0);
      tick();                                   // I+4: DONE
      bus.output_valid_i = 1'b0;
      chk("basic_done",   32'(bus.done_o), 32'd1);
      chk("basic_result", bus.result_o, 32'h4020_0000);
      chk("basic_busy0",  32'(bus.busy_o), 32'd0);
      bus.wr_en_i   = 1'b1;                     // write during DONE is accepted
      bus.wr_addr_i = 4'd15;
      bus.wr_data_i = 32'h1111_1111;
      tick();                                   // IDLE
      bus.wr_en_i = 1'b0;
      chk("basic_done_pulse", 32'(bus.done_o), 32'd0);
      chk("done_wr_reg15",    bus.fprti_regs_o[15], 32'h1111_1111);
      chk("done_wr_noreject", 32'(bus.wr_reject_o), 32'd0);

      // Timeout with silent responder
      bus.start_i = 1'b1;
      tick();                                   // ISSUE (I)
      bus.start_i = 1'b0;
      chk("tmo_ivalid", 32'(bus.input_valid_o), 32'd1);
      repeat (8) tick();                        // I+8
      chk("tmo_nodone_i8", 32'(bus.done_o), 32'd0);
      tick();                                   // I+9
      chk("tmo_done",   32'(bus.done_o), 32'd1);
      chk("tmo_result", bus.result_o, 32'h7FC0_0000);
      chk("tmo_flag",   32'(bus.timeout_o), 32'd1);
      tick();                                   // IDLE: stray result ignored
      bus.output_valid_i = 1'b1;
      bus.return_i       = 32'h5555_5555;
      tick();
      bus.output_valid_i = 1'b0;
      chk("idle_ov_ignored", bus.result_o, 32'h7FC0_0000);
      chk("tmo_sticky",      32'(bus.timeout_o), 32'd1);
      chk("idle_no_done",    32'(bus.done_o), 32'd0);

      // Edge race: result on the terminal-count cycle
      bus.start_i = 1'b1;
      tick();                                   // ISSUE (I)
      bus.start_i = 1'b0;
      chk("tmo_clear_on_issue", 32'(bus.timeout_o), 32'd0);
      repeat (8) tick();                        // I+8: terminal count
      bus.output_valid_i = 1'b1;
      bus.return_i       = 32'h1234_5678;
      tick();                                   // I+9
      bus.output_valid_i = 1'b0;
      chk("race_done",   32'(bus.done_o), 32'd1);
      chk("race_result", bus.result_o, 32'h1234_5678);
      chk("race_tmo",    32'(bus.timeout_o), 32'd0);
      tick();                                   // IDLE

      // Busy protection
      bus.start_i = 1'b1;
      tick();                                   // ISSUE (I)
      bus.start_i = 1'b0;
      tick();                                   // I+1 WAIT
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 4'd3;
      bus.wr_data_i = 32'hFFFF_FFFF;
      bus.start_i   = 1'b1;
      tick();                                   // I+2
      bus.wr_en_i = 1'b0;
      bus.start_i = 1'b0;
      chk("busy_reject",   32'(bus.wr_reject_o), 32'd1);
      chk("busy_reg3",     bus.fprti_regs_o[3], 32'h3F80_0003);
      chk("busy_no_issue", 32'(bus.input_valid_o), 32'd0);
      tick();                                   // I+3
      chk("busy_reject_pulse", 32'(bus.wr_reject_o), 32'd0);
      bus.output_valid_i = 1'b1;
      bus.return_i       = 32'hAAAA_5555;
      tick();                                   // I+4 DONE
      bus.output_valid_i = 1'b0;
      chk("busy_done",   32'(bus.done_o), 32'd1);
      chk("busy_result", bus.result_o, 32'hAAAA_5555);
      tick();                                   // IDLE
      tick();
      chk("busy_no_queue_iv", 32'(bus.input_valid_o), 32'd0);
      chk("busy_no_queue_bz", 32'(bus.busy_o), 32'd0);

      // Same-cycle write and start
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 4'd5;
      bus.wr_data_i = 32'hDEAD_BEEF;
      bus.start_i   = 1'b1;
      tick();                                   // ISSUE
      bus.wr_en_i = 1'b0;
      bus.start_i = 1'b0;
      chk("wrstart_ivalid", 32'(bus.input_valid_o), 32'd1);
      chk("wrstart_reg5",   bus.fprti_regs_o[5], 32'hDEAD_BEEF);
      chk("wrstart_noreject", 32'(bus.wr_reject_o), 32'd0);

      // Reset mid-WAIT
      tick();                                   // WAIT
      tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_busy",   32'(bus.busy_o), 32'd0);
      chk("mrst_result", bus.result_o, 32'd0);
      chk("mrst_reg5",   bus.fprti_regs_o[5], 32'd0);
      chk("mrst_done",   32'(bus.done_o), 32'd0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      bus.output_valid_i = 1'b1;
      bus.return_i       = 32'hBBBB_BBBB;
      tick();
      bus.output_valid_i = 1'b0;
      chk("mrst_late_done",   32'(bus.done_o), 32'd0);
      chk("mrst_late_result", bus.result_o, 32'd0);
      tick();
      chk("mrst_late_done2",  32'(bus.done_o), 32'd0);
      chk("mrst_late_busy",   32'(bus.busy_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
